mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single data-side port of the memory controller between two masters: M0 (CPU load/store unit) and M1 (UART loader / debug master).
- Sits between the requesters and the controller's data inputs (address, write data, width, write enable, read enable, zero-extend).
- Round-robin arbitration with optional bounded bus locking.
- Routes 1-cycle-latency read data back to the master that issued the read.

Parameters:
- MAX_LOCK, 16, maximum consecutive locked grants to one master before a forced release; legal range 1..255.
- M0_FIRST, 1, 1: M0 wins the first contested arbitration after reset; 0: M1 wins it.

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_mX_req  in  1  request from master X (X = 0, 1); one set of these master ports per master
- i_mX_lock  in  1  keep grant on next cycle if still requesting
- i_mX_addr  in  32  byte address
- i_mX_wdata  in  32  write data
- i_mX_width  in  2  1 = byte, 2 = half, other = word
- i_mX_we  in  1  write enable
- i_mX_zext  in  1  zero-extend loads
- o_mX_gnt  out  1  transfer accepted this cycle (combinational)
- o_mX_rvalid  out  1  read data valid (registered)
- o_mX_rdata  out  32  read data; equals i_mem_rdata when o_mX_rvalid is high, else 0
- o_mem_addr  out  32  to controller data address
- o_mem_wdata  out  32  to controller write data
- o_mem_width  out  2  to controller width
- o_mem_we  out  1  to controller write enable
- o_mem_read_en  out  1  to controller read enable
- o_mem_zext  out  1  to controller zero-extend
- i_mem_rdata  in  32  controller read data, valid the cycle after the read is issued

Behaviour:
- States: IDLE, OWN0, OWN1. State records the previous-cycle grant holder; reset state is IDLE.
- Reset values:
  - last_grant = M0_FIRST ? 1 : 0 (the opposite master is favoured first).
  - lock_cnt = 0; pending read = none.
  - All o_*_rvalid = 0.
  - o_mem_we = 0 and o_mem_read_en = 0; all other outputs 0 while no request is present.
- Grant selection, combinational each cycle:
  - Neither master requesting: no grant; o_mem_* all 0; next state IDLE.
  - Only one master requesting: grant it.
  - Both requesting, state OWNx, i_mx_lock was high last cycle, and lock_cnt < MAX_LOCK: grant x (lock honoured).
  - Both requesting, otherwise: grant the master that is not last_grant.
- Lock counting:
  - lock_cnt increments on each locked re-grant to the same owner.
  - lock_cnt clears to 0 on an ownership change or when the owner drops its request.
  - Forced release when lock_cnt reaches MAX_LOCK: the other master gets exactly one grant, then lock is evaluated afresh.
  - An uncontested master is never forced off; lock_cnt saturates at MAX_LOCK.
- Issue path:
  - The granted master's addr, wdata, width, we and zext are muxed onto o_mem_*.
  - o_mem_read_en = gnt & ~we.
  - At most one transfer is issued per cycle.
  - o_mX_gnt is high only for the selected master.
  - last_grant updates to the granted master on each grant.
- Response path:
  - On a read issue, register the read id.
  - Next cycle: o_mX_rvalid = 1 for that id only; o_mX_rdata = i_mem_rdata.
  - Writes produce no rvalid.
- Back-to-back: a new grant in the same cycle as an rvalid is legal; reads pipeline at 1 per cycle.
- Simultaneous lock from both masters: only the current owner's lock counts.
- Reset asserted mid-read: the pending read is discarded; no rvalid follows reset release.
- A request dropped without a grant is not remembered.

Optional Feature:
- Macro: MEM_ARB_PERF_EN
- With the macro:
  - Adds three 32-bit outputs: o_perf_gnt0, o_perf_gnt1 (grant counts) and o_perf_stall (cycles in which a requesting master was not granted).
  - All three saturate at 0xFFFF_FFFF and reset to 0 on i_rst_n.
- Without the macro: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Only M0 requests a word read of 0x4000_0010 with i_mem_rdata = 0xDEADBEEF next cycle -> o_m0_gnt = 1 in cycle 0; o_mem_read_en = 1 and o_mem_addr = 0x4000_0010 in cycle 0; o_m0_rvalid = 1 with o_m0_rdata = 0xDEADBEEF in cycle 1; o_m1_rvalid = 0 throughout.
- Both masters request continuously with no lock, reset default -> grants M0, M1, M0, M1 ...; each master is stalled every other cycle.
- MAX_LOCK = 4; M1 owns the port with i_m1_lock = 1; M0 then requests continuously -> M1 receives 4 further consecutive grants, then M0 gets 1 grant, then M1 resumes locking.
- M1 issues a byte write 0xA5 to 0x2000_0003, followed by a read in the next cycle -> o_mem_we = 1 and o_mem_width = 1 in cycle 0; no rvalid for the write; o_m1_rvalid = 1 exactly once, in cycle 2.
- M0 read issued, then i_rst_n pulsed low before the next edge -> no rvalid on either master after reset release; state is IDLE; first contested grant goes to M0.
- With MEM_ARB_PERF_EN: 10 cycles of both masters requesting -> o_perf_gnt0 = 5, o_perf_gnt1 = 5, o_perf_stall = 10.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter for the memory controller data port, with bounded bus locking.
// Optional performance counters are built when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter #(
    parameter int unsigned MAX_LOCK = 16,
    parameter bit          M0_FIRST = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_m0_req,
    input  logic        i_m0_lock,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wdata,
    input  logic [1:0]  i_m0_width,
    input  logic        i_m0_we,
    input  logic        i_m0_zext,
    output logic        o_m0_gnt,
    output logic        o_m0_rvalid,
    output logic [31:0] o_m0_rdata,
    input  logic        i_m1_req,
    input  logic        i_m1_lock,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wdata,
    input  logic [1:0]  i_m1_width,
    input  logic        i_m1_we,
    input  logic        i_m1_zext,
    output logic        o_m1_gnt,
    output logic        o_m1_rvalid,
    output logic [31:0] o_m1_rdata,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [1:0]  o_mem_width,
    output logic        o_mem_we,
    output logic        o_mem_read_en,
    output logic        o_mem_zext,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0] o_perf_gnt0,
    output logic [31:0] o_perf_gnt1,
    output logic [31:0] o_perf_stall,
`endif
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

    state_e     state_q, state_d;
    logic       last_grant_q, last_grant_d;   // 0 = M0, 1 = M1
    logic       lock_q, lock_d;               // owner's lock as seen last cycle
    logic [7:0] lock_cnt_q, lock_cnt_d;
    logic       rd_valid_q, rd_id_q;
    logic       gnt0, gnt1;
    logic       owner_lock, regrant;

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        owner_lock   = lock_q && (lock_cnt_q < MAX_LOCK_C);
        if (i_m0_req && i_m1_req) begin
            if (state_q == OWN0 && owner_lock)      gnt0 = 1'b1;
            else if (state_q == OWN1 && owner_lock) gnt1 = 1'b1;
            else if (last_grant_q)                  gnt0 = 1'b1;
            else                                    gnt1 = 1'b1;
        end else if (i_m0_req) begin
            gnt0 = 1'b1;
        end else if (i_m1_req) begin
            gnt1 = 1'b1;
        end

        state_d      = gnt0 ? OWN0 : (gnt1 ? OWN1 : IDLE);
        last_grant_d = gnt0 ? 1'b0 : (gnt1 ? 1'b1 : last_grant_q);
        lock_d       = gnt0 ? i_m0_lock : (gnt1 ? i_m1_lock : 1'b0);

        // Only a locked re-grant to the same owner extends the run; anything else restarts it.
        regrant      = (gnt0 && state_q == OWN0) || (gnt1 && state_q == OWN1);
        lock_cnt_d   = 8'd0;
        if (regrant && lock_q)
            lock_cnt_d = (lock_cnt_q >= MAX_LOCK_C) ? MAX_LOCK_C : lock_cnt_q + 8'd1;
    end

    always_comb begin
        o_mem_addr    = 32'd0;
        o_mem_wdata   = 32'd0;
        o_mem_width   = 2'd0;
        o_mem_we      = 1'b0;
        o_mem_zext    = 1'b0;
        o_mem_read_en = 1'b0;
        if (gnt0) begin
            o_mem_addr    = i_m0_addr;
            o_mem_wdata   = i_m0_wdata;
            o_mem_width   = i_m0_width;
            o_mem_we      = i_m0_we;
            o_mem_zext    = i_m0_zext;
            o_mem_read_en = ~i_m0_we;
        end else if (gnt1) begin
            o_mem_addr    = i_m1_addr;
            o_mem_wdata   = i_m1_wdata;
            o_mem_width   = i_m1_width;
            o_mem_we      = i_m1_we;
            o_mem_zext    = i_m1_zext;
            o_mem_read_en = ~i_m1_we;
        end
    end

    assign o_m0_gnt = gnt0;
    assign o_m1_gnt = gnt1;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= M0_FIRST ? 1'b1 : 1'b0;
            lock_q       <= 1'b0;
            lock_cnt_q   <= 8'd0;
            rd_valid_q   <= 1'b0;
            rd_id_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lock_q       <= lock_d;
            lock_cnt_q   <= lock_cnt_d;
            rd_valid_q   <= o_mem_read_en;
            rd_id_q      <= gnt1;
        end
    end

    // Read data is steered to whichever master issued the read one cycle earlier.
    assign o_m0_rvalid = rd_valid_q & ~rd_id_q;
    assign o_m1_rvalid = rd_valid_q &  rd_id_q;
    assign o_m0_rdata  = o_m0_rvalid ? i_mem_rdata : 32'd0;
    assign o_m1_rdata  = o_m1_rvalid ? i_mem_rdata : 32'd0;

`ifdef MEM_ARB_PERF_EN
    logic stall;
    assign stall = (i_m0_req & ~gnt0) | (i_m1_req & ~gnt1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_perf_gnt0  <= 32'd0;
            o_perf_gnt1  <= 32'd0;
            o_perf_stall <= 32'd0;
        end else begin
            if (gnt0 && o_perf_gnt0 != 32'hFFFF_FFFF)   o_perf_gnt0  <= o_perf_gnt0 + 32'd1;
            if (gnt1 && o_perf_gnt1 != 32'hFFFF_FFFF)   o_perf_gnt1  <= o_perf_gnt1 + 32'd1;
            if (stall && o_perf_stall != 32'hFFFF_FFFF) o_perf_stall <= o_perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MAX_LOCK = 4, M0_FIRST = 1).
module tb_mem_port_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_m0_req, i_m0_lock, i_m0_we, i_m0_zext;
    logic [31:0] i_m0_addr, i_m0_wdata;
    logic [1:0]  i_m0_width;
    logic        i_m1_req, i_m1_lock, i_m1_we, i_m1_zext;
    logic [31:0] i_m1_addr, i_m1_wdata;
    logic [1:0]  i_m1_width;
    logic        o_m0_gnt, o_m0_rvalid, o_m1_gnt, o_m1_rvalid;
    logic [31:0] o_m0_rdata, o_m1_rdata;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [1:0]  o_mem_width;
    logic        o_mem_we, o_mem_read_en, o_mem_zext;
    logic [31:0] i_mem_rdata;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] o_perf_gnt0, o_perf_gnt1, o_perf_stall;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    mem_port_arbiter #(.MAX_LOCK(4), .M0_FIRST(1'b1)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_m0_req(i_m0_req), .i_m0_lock(i_m0_lock), .i_m0_addr(i_m0_addr),
        .i_m0_wdata(i_m0_wdata), .i_m0_width(i_m0_width), .i_m0_we(i_m0_we),
        .i_m0_zext(i_m0_zext), .o_m0_gnt(o_m0_gnt), .o_m0_rvalid(o_m0_rvalid),
        .o_m0_rdata(o_m0_rdata),
        .i_m1_req(i_m1_req), .i_m1_lock(i_m1_lock), .i_m1_addr(i_m1_addr),
        .i_m1_wdata(i_m1_wdata), .i_m1_width(i_m1_width), .i_m1_we(i_m1_we),
        .i_m1_zext(i_m1_zext), .o_m1_gnt(o_m1_gnt), .o_m1_rvalid(o_m1_rvalid),
        .o_m1_rdata(o_m1_rdata),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_width(o_mem_width),
        .o_mem_we(o_mem_we), .o_mem_read_en(o_mem_read_en), .o_mem_zext(o_mem_zext),
`ifdef MEM_ARB_PERF_EN
        .o_perf_gnt0(o_perf_gnt0), .o_perf_gnt1(o_perf_gnt1), .o_perf_stall(o_perf_stall),
`endif
        .i_mem_rdata(i_mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_m0_req = 0; i_m0_lock = 0; i_m0_we = 0; i_m0_zext = 0;
        i_m0_addr = 0; i_m0_wdata = 0; i_m0_width = 0;
        i_m1_req = 0; i_m1_lock = 0; i_m1_we = 0; i_m1_zext = 0;
        i_m1_addr = 0; i_m1_wdata = 0; i_m1_width = 0;
        i_mem_rdata = 0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        i_rst_n = 0;
        tick();
        i_rst_n = 1;
        #1;
    endtask

    bit lock_seq [7] = '{1, 1, 1, 1, 0, 1, 1};

    initial begin
        // Reset state
        clear_inputs();
        i_rst_n = 0;
        #3;
        check("rst_m0_rvalid", 32'(o_m0_rvalid), 32'd0);
        check("rst_m1_rvalid", 32'(o_m1_rvalid), 32'd0);
        check("rst_mem_we", 32'(o_mem_we), 32'd0);
        check("rst_mem_read_en", 32'(o_mem_read_en), 32'd0);
        check("rst_mem_addr", o_mem_addr, 32'd0);
        tick();
        i_rst_n = 1;
        tick();

        // Single M0 word read
        i_m0_req = 1; i_m0_addr = 32'h4000_0010; i_m0_width = 2'd3; i_m0_we = 0;
        #1;
        check("rd_m0_gnt", 32'(o_m0_gnt), 32'd1);
        check("rd_m1_gnt", 32'(o_m1_gnt), 32'd0);
        check("rd_read_en", 32'(o_mem_read_en), 32'd1);
        check("rd_addr", o_mem_addr, 32'h4000_0010);
        check("rd_width", 32'(o_mem_width), 32'd3);
        tick();
        i_m0_req = 0; i_mem_rdata = 32'hDEAD_BEEF;
        #1;
        check("rd_m0_rvalid", 32'(o_m0_rvalid), 32'd1);
        check("rd_m0_rdata", o_m0_rdata, 32'hDEAD_BEEF);
        check("rd_m1_rvalid", 32'(o_m1_rvalid), 32'd0);
        check("rd_m1_rdata", o_m1_rdata, 32'd0);
        check("idle_mem_read_en", 32'(o_mem_read_en), 32'd0);
        tick();
        check("rd_m0_rvalid_done", 32'(o_m0_rvalid), 32'd0);
        check("rd_m0_rdata_zero", o_m0_rdata, 32'd0);

        // Round robin, both requesting writes, no lock
        reset_dut();
        i_m0_req = 1; i_m0_we = 1; i_m0_addr = 32'h100;
        i_m1_req = 1; i_m1_we = 1; i_m1_addr = 32'h200;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("rr_gnt0_%0d", i), 32'(o_m0_gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("rr_gnt1_%0d", i), 32'(o_m1_gnt), (i % 2 == 0) ? 32'd0 : 32'd1);
            check($sformatf("rr_addr_%0d", i), o_mem_addr, (i % 2 == 0) ? 32'h100 : 32'h200);
            tick();
        end
        check("rr_no_rvalid", 32'(o_m0_rvalid | o_m1_rvalid), 32'd0);

        // Bounded lock: M1 owns alone, then M0 contends
        reset_dut();
        i_m1_req = 1; i_m1_lock = 1; i_m1_we = 1;
        #1;
        check("lk_own_gnt1", 32'(o_m1_gnt), 32'd1);
        tick();
        i_m0_req = 1; i_m0_we = 1;
        for (int i = 0; i < 7; i++) begin
            #1;
            check($sformatf("lk_gnt1_%0d", i), 32'(o_m1_gnt), 32'(lock_seq[i]));
            check($sformatf("lk_gnt0_%0d", i), 32'(o_m0_gnt), 32'(!lock_seq[i]));
            tick();
        end

        // M1 byte write then read
        reset_dut();
        i_m1_req = 1; i_m1_we = 1; i_m1_width = 2'd1;
        i_m1_addr = 32'h2000_0003; i_m1_wdata = 32'h0000_00A5;
        #1;
        check("bw_gnt1", 32'(o_m1_gnt), 32'd1);
        check("bw_we", 32'(o_mem_we), 32'd1);
        check("bw_width", 32'(o_mem_width), 32'd1);
        check("bw_wdata", o_mem_wdata, 32'h0000_00A5);
        check("bw_addr", o_mem_addr, 32'h2000_0003);
        check("bw_read_en", 32'(o_mem_read_en), 32'd0);
        tick();
        i_m1_we = 0; i_m1_width = 2'd2; i_m1_addr = 32'h2000_0000; i_m1_zext = 1;
        #1;
        check("bw_c1_rvalid", 32'(o_m1_rvalid), 32'd0);
        check("bw_c1_read_en", 32'(o_mem_read_en), 32'd1);
        check("bw_c1_zext", 32'(o_mem_zext), 32'd1);
        tick();
        i_m1_req = 0; i_mem_rdata = 32'h1234_5678;
        #1;
        check("bw_c2_rvalid", 32'(o_m1_rvalid), 32'd1);
        check("bw_c2_rdata", o_m1_rdata, 32'h1234_5678);
        check("bw_c2_m0_rvalid", 32'(o_m0_rvalid), 32'd0);
        tick();
        check("bw_c3_rvalid", 32'(o_m1_rvalid), 32'd0);

        // Reset pulse while a read is pending
        reset_dut();
        i_m1_req = 1; i_m1_we = 1;
        tick();                       // last grant now M1
        i_m1_req = 0; i_m1_we = 0;
        i_m0_req = 1; i_m0_addr = 32'h0000_0040;
        #1;
        check("rr_rst_gnt0", 32'(o_m0_gnt), 32'd1);
        tick();                       // read issued; last grant now M0
        i_m0_req = 0; i_mem_rdata = 32'hCAFE_F00D;
        #1;
        check("rr_rst_pre_rvalid", 32'(o_m0_rvalid), 32'd1);
        i_m0_req = 1;
        #1;
        check("rr_rst_read_issue", 32'(o_mem_read_en), 32'd1);
        #1;
        i_rst_n = 0;
        #1;
        check("rr_rst_rvalid_async", 32'(o_m0_rvalid), 32'd0);
        i_m0_req = 0;
        #1;
        i_rst_n = 1;
        tick();
        check("rr_rst_m0_rvalid", 32'(o_m0_rvalid), 32'd0);
        check("rr_rst_m1_rvalid", 32'(o_m1_rvalid), 32'd0);
        i_m0_req = 1; i_m0_we = 1; i_m1_req = 1; i_m1_we = 1;
        #1;
        check("rr_rst_first_gnt0", 32'(o_m0_gnt), 32'd1);
        check("rr_rst_first_gnt1", 32'(o_m1_gnt), 32'd0);
        tick();
        check("rr_rst_late_rvalid", 32'(o_m0_rvalid | o_m1_rvalid), 32'd0);

`ifdef MEM_ARB_PERF_EN
        // Performance counters over 10 contested cycles
        reset_dut();
        check("perf_rst_gnt0", o_perf_gnt0, 32'd0);
        check("perf_rst_stall", o_perf_stall, 32'd0);
        i_m0_req = 1; i_m0_we = 1; i_m1_req = 1; i_m1_we = 1;
        for (int i = 0; i < 10; i++) tick();
        clear_inputs();
        #1;
        check("perf_gnt0", o_perf_gnt0, 32'd5);
        check("perf_gnt1", o_perf_gnt1, 32'd5);
        check("perf_stall", o_perf_stall, 32'd10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
